// File: rtl/area_accumulator_if.sv
// Two /dav-rfd handshakes around the area accumulator: areas arrive on the
// input side, batch totals leave on the output side.
interface area_accumulator_if;
  logic [15:0] data_in;
  logic        dav_in_;
  logic        rfd_in;
  logic [23:0] data_out;
  logic        dav_out_;
  logic        rfd_out;

  modport slave (
    input  data_in,
    input  dav_in_,
    output rfd_in,
    output data_out,
    output dav_out_,
    input  rfd_out
  );

  modport master (
    output data_in,
    output dav_in_,
    input  rfd_in,
    input  data_out,
    input  dav_out_,
    output rfd_out
  );
endinterface

// File: rtl/area_accumulator.sv
// Sums BATCH consecutive 16-bit areas taken over a /dav-rfd handshake and
// hands the 24-bit total to a consumer over a second /dav-rfd handshake.
module area_accumulator #(
  parameter int unsigned BATCH = 4
) (
  input  logic              clock,
  input  logic              reset,
  area_accumulator_if.slave bus
);

  localparam logic [7:0] BATCH_CNT = 8'(BATCH);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } star_t;

  star_t       r_star;
  logic [23:0] r_acc;
  logic [7:0]  r_cnt;
  logic [23:0] r_out;
  logic        r_hs_l;
  logic        r_hs_r;

  logic [23:0] w_area_ext;
  logic [23:0] w_sum;
  logic        w_batch_full;

  function automatic logic [23:0] zext_area(input logic [15:0] area);
    return {8'h00, area};
  endfunction

  assign w_area_ext   = zext_area(bus.data_in);
  assign w_sum        = r_acc + w_area_ext;
  assign w_batch_full = (r_cnt == BATCH_CNT);

  // Handshake sequencer; every output is taken straight from its registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_star <= S0;
      r_acc  <= 24'd0;
      r_cnt  <= 8'd0;
      r_out  <= 24'd0;
      r_hs_l <= 1'b1;
      r_hs_r <= 1'b1;
    end else begin
      case (r_star)
        S0: begin
          if (!bus.dav_in_) begin
            r_acc  <= w_sum;
            r_cnt  <= r_cnt + 8'd1;
            r_hs_l <= 1'b0;
            r_star <= S1;
          end else begin
            r_star <= S0;
          end
        end
        S1: begin
          // Waiting for the producer to release keeps a long-held area counted once.
          if (bus.dav_in_) begin
            if (w_batch_full) begin
              r_star <= S2;
            end else begin
              r_hs_l <= 1'b1;
              r_star <= S0;
            end
          end else begin
            r_star <= S1;
          end
        end
        S2: begin
          if (bus.rfd_out) begin
            r_out  <= r_acc;
            r_hs_r <= 1'b0;
            r_star <= S3;
          end else begin
            r_star <= S2;
          end
        end
        S3: begin
          if (!bus.rfd_out) begin
            r_hs_r <= 1'b1;
            r_acc  <= 24'd0;
            r_cnt  <= 8'd0;
            r_hs_l <= 1'b1;
            r_star <= S0;
          end else begin
            r_star <= S3;
          end
        end
        default: begin
          r_star <= S0;
          r_acc  <= 24'd0;
          r_cnt  <= 8'd0;
          r_hs_l <= 1'b1;
          r_hs_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rfd_in   = r_hs_l;
  assign bus.dav_out_ = r_hs_r;
  assign bus.data_out = r_out;

endmodule

// File: tb/tb_area_accumulator.sv
// Scoreboard bench: two accumulators (BATCH=4 and BATCH=1) driven by directed
// and random producers; a per-DUT monitor compares each delivered total.
module tb_area_accumulator;

  localparam int BATCH_A = 4;
  localparam int BATCH_B = 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  area_accumulator_if ifa ();
  area_accumulator_if ifb ();

  area_accumulator #(.BATCH(BATCH_A)) dut_a (.clock(clk), .reset(reset), .bus(ifa));
  area_accumulator #(.BATCH(BATCH_B)) dut_b (.clock(clk), .reset(reset), .bus(ifb));

  // Reference model: partial batch per DUT, expected totals in queues.
  int          psum   [2];
  int          pcnt   [2];
  int          pushes [2];
  int          pulses [2];
  logic [23:0] expq_a [$];
  logic [23:0] expq_b [$];
  logic        stall_a;
  logic        rand_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic int batch_of(input int w);
    return (w == 0) ? BATCH_A : BATCH_B;
  endfunction

  function automatic int qsize(input int w);
    return (w == 0) ? expq_a.size() : expq_b.size();
  endfunction

  function automatic logic get_rfd(input int w);
    return (w == 0) ? ifa.rfd_in : ifb.rfd_in;
  endfunction

  task automatic drive_in(input int w, input logic dav, input logic [15:0] d);
    if (w == 0) begin
      ifa.dav_in_ = dav;
      ifa.data_in = d;
    end else begin
      ifb.dav_in_ = dav;
      ifb.data_in = d;
    end
  endtask

  task automatic model_accept(input int w, input logic [15:0] v);
    psum[w] += int'(v);
    pcnt[w]++;
    if (pcnt[w] == batch_of(w)) begin
      if (w == 0) expq_a.push_back(24'(psum[w]));
      else        expq_b.push_back(24'(psum[w]));
      pushes[w]++;
      psum[w] = 0;
      pcnt[w] = 0;
    end
  endtask

  task automatic send_area(input int w, input logic [15:0] v, input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (get_rfd(w) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      timeout_fail("rfd_in_rise");
      return;
    end
    drive_in(w, 1'b0, v);
    model_accept(w, v);
    n = 0;
    @(negedge clk);
    while (get_rfd(w) !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout_fail("rfd_in_fall");
    repeat (hold) @(negedge clk);
    drive_in(w, 1'b1, 16'($urandom));
  endtask

  task automatic wait_drain(input int w);
    int n;
    n = 0;
    while (qsize(w) != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 500) timeout_fail("output_drain");
  endtask

  function automatic logic [15:0] rand_area();
    case ($urandom_range(0, 3))
      0:       return 16'd0;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Consumer: raise rfd_out while idle, drop it as soon as dav_out_ is seen.
  initial begin
    ifa.rfd_out = 1'b1;
    ifb.rfd_out = 1'b1;
    forever begin
      @(negedge clk);
      ifa.rfd_out = !stall_a && ifa.dav_out_ && (!rand_stall || $urandom_range(0, 3) != 0);
      ifb.rfd_out = ifb.dav_out_ && (!rand_stall || $urandom_range(0, 3) != 0);
    end
  end

  initial begin : mon_a
    logic prev;
    logic [23:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else begin
        if (ifa.dav_out_ === 1'b0 && prev) begin
          pulses[0]++;
          if (expq_a.size() == 0) begin
            check_eq("a_extra_output", pulses[0], pushes[0]);
          end else begin
            e = expq_a.pop_front();
            check_eq("a_total", {8'd0, ifa.data_out}, {8'd0, e});
            check_eq("a_rfd_in_busy", {31'd0, ifa.rfd_in}, 32'd0);
          end
        end
        prev = ifa.dav_out_;
      end
    end
  end

  initial begin : mon_b
    logic prev;
    logic [23:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else begin
        if (ifb.dav_out_ === 1'b0 && prev) begin
          pulses[1]++;
          if (expq_b.size() == 0) begin
            check_eq("b_extra_output", pulses[1], pushes[1]);
          end else begin
            e = expq_b.pop_front();
            check_eq("b_total", {8'd0, ifb.data_out}, {8'd0, e});
          end
        end
        prev = ifb.dav_out_;
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    stall_a = 1'b0;
    rand_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      psum[i] = 0;
      pcnt[i] = 0;
      pushes[i] = 0;
      pulses[i] = 0;
    end
    drive_in(0, 1'b1, 16'd0);
    drive_in(1, 1'b1, 16'd0);

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check_eq("rst_a_rfd_in", {31'd0, ifa.rfd_in}, 32'd1);
    check_eq("rst_a_dav_out", {31'd0, ifa.dav_out_}, 32'd1);
    check_eq("rst_a_data_out", {8'd0, ifa.data_out}, 32'd0);
    check_eq("rst_b_rfd_in", {31'd0, ifb.rfd_in}, 32'd1);
    check_eq("rst_b_dav_out", {31'd0, ifb.dav_out_}, 32'd1);
    check_eq("rst_b_data_out", {8'd0, ifb.data_out}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Nominal batch.
    send_area(0, 16'd10, 0);
    send_area(0, 16'd20, 1);
    send_area(0, 16'd30, 0);
    send_area(0, 16'd40, 2);
    wait_drain(0);
    @(negedge clk);
    check_eq("nom_dav_out_release", {31'd0, ifa.dav_out_}, 32'd1);
    check_eq("nom_rfd_in_release", {31'd0, ifa.rfd_in}, 32'd1);
    check_eq("nom_data_out_held", {8'd0, ifa.data_out}, 32'd100);

    // Maximum areas, then a small batch to show the sum was cleared.
    for (int i = 0; i < 4; i++) send_area(0, 16'hFFFF, $urandom_range(0, 2));
    wait_drain(0);
    @(negedge clk);
    check_eq("max_data_out", {8'd0, ifa.data_out}, 32'd262140);
    for (int i = 0; i < 4; i++) send_area(0, 16'd1, 0);
    wait_drain(0);
    @(negedge clk);
    check_eq("ones_data_out", {8'd0, ifa.data_out}, 32'd4);

    // Consumer stall holds the producer off.
    stall_a = 1'b1;
    send_area(0, 16'd3, 0);
    send_area(0, 16'd500, 0);
    send_area(0, 16'd7, 0);
    send_area(0, 16'd9000, 0);
    repeat (10) begin
      @(negedge clk);
      check_eq("stall_rfd_in", {31'd0, ifa.rfd_in}, 32'd0);
      check_eq("stall_dav_out", {31'd0, ifa.dav_out_}, 32'd1);
    end
    #1 stall_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("stall_dav_out_fall", {31'd0, ifa.dav_out_}, 32'd0);
    check_eq("stall_data_out", {8'd0, ifa.data_out}, 32'd9510);
    wait_drain(0);
    @(negedge clk);

    // Reset in the middle of a batch drops the partial sum.
    send_area(0, 16'd5, 0);
    send_area(0, 16'd7, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_rfd_in", {31'd0, ifa.rfd_in}, 32'd1);
    check_eq("midrst_dav_out", {31'd0, ifa.dav_out_}, 32'd1);
    check_eq("midrst_data_out", {8'd0, ifa.data_out}, 32'd0);
    psum[0] = 0;
    pcnt[0] = 0;
    @(negedge clk);
    reset = 1'b0;
    send_area(0, 16'd1, 0);
    send_area(0, 16'd2, 0);
    send_area(0, 16'd3, 0);
    send_area(0, 16'd4, 0);
    wait_drain(0);
    @(negedge clk);
    check_eq("after_rst_data_out", {8'd0, ifa.data_out}, 32'd10);

    // BATCH=1 with a long-held area: one total, one pulse.
    send_area(1, 16'd300, 6);
    wait_drain(1);
    repeat (5) @(negedge clk);
    check_eq("hold_pulses", pulses[1], 32'd1);
    check_eq("hold_data_out", {8'd0, ifb.data_out}, 32'd300);

    // Random traffic on both DUTs with a randomly hesitant consumer.
    rand_stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) send_area(0, rand_area(), $urandom_range(0, 3));
      end
      begin
        for (int j = 0; j < 12; j++) send_area(1, rand_area(), $urandom_range(0, 3));
      end
    join
    wait_drain(0);
    wait_drain(1);
    rand_stall = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("final_pulses_a", pulses[0], pushes[0]);
    check_eq("final_pulses_b", pulses[1], pushes[1]);
    check_eq("final_queue_a", expq_a.size(), 32'd0);
    check_eq("final_queue_b", expq_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
